// File: rtl/comparator_serial_msb.sv
// comparator_serial_msb: MSB-first serial magnitude comparator, DIGIT bits per clock with early exit
module comparator_serial_msb #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             et,
    output logic             gt
);
    localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int P  = N * DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t           state, state_nxt;
    logic [P-1:0]     sa, sb;
    logic [CW-1:0]    cnt;
    logic [2:0]       leg, res_nxt;
    logic [DIGIT-1:0] ta, tb;

    assign ta = sa[P-1 -: DIGIT];
    assign tb = sb[P-1 -: DIGIT];

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    // next state and result: first unequal top digit decides, full equality passes l/e/g through
    always_comb begin
        state_nxt = state;
        res_nxt   = {lt, et, gt};
        case (state)
            IDLE:    state_nxt = start ? COMPARE : IDLE;
            COMPARE: if (ta != tb || cnt == '0) begin
                state_nxt = DONE;
                res_nxt   = ta > tb ? 3'b001 : ta < tb ? 3'b100 : leg;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand shift registers and digit counter; padding zeros sit above the MSB
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            leg <= '0;
        end else if (state == IDLE && start) begin
            sa  <= P'(A);
            sb  <= P'(B);
            leg <= {l, e, g};
            cnt <= CW'(N - 1);
        end else if (state == COMPARE && state_nxt == COMPARE) begin
            sa  <= sa << DIGIT;
            sb  <= sb << DIGIT;
            cnt <= cnt - CW'(1);
        end

    // registered outputs; the result only changes on entry to DONE
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            {lt, et, gt} <= 3'b000;
        end else begin
            busy         <= state_nxt != IDLE;
            done         <= state_nxt == DONE;
            {lt, et, gt} <= res_nxt;
        end
endmodule

// File: tb/tb_comparator_serial_msb.sv
// tb_comparator_serial_msb: directed vectors plus a cycle-level reference model for comparator_serial_msb
module tb_comparator_serial_msb;
    localparam int W = 8;
    localparam int D = 3;
    localparam int N = (W + D - 1) / D;
    localparam int P = N * D;

    logic         clk = 0, rst_n = 0, start = 0;
    logic [W-1:0] A = '0, B = '0;
    logic         l = 0, e = 0, g = 0;
    logic         busy, done, lt, et, gt;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0;
    bit chk_en = 0;

    logic       m_busy = 0, m_done = 0;
    logic [2:0] m_res = 0, pend = 0;
    int         rem = 0;

    comparator_serial_msb #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .l(l), .e(e), .g(g), .busy(busy), .done(done), .lt(lt), .et(et), .gt(gt)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_res(input int a, input int b, input logic [2:0] leg);
        return a > b ? 3'b001 : a < b ? 3'b100 : leg;
    endfunction

    // edges from acceptance until DONE is entered: position of first differing digit, MSB first
    function automatic int ref_lat(input int a, input int b);
        for (int k = 0; k < N; k++)
            if (((a >> (P - D * (k + 1))) & ((1 << D) - 1)) != ((b >> (P - D * (k + 1))) & ((1 << D) - 1)))
                return k + 1;
        return N;
    endfunction

    always @(posedge clk) cyc++;

    // reference model: one transaction at a time, counted down in clock edges
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_res = 0; rem = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            rem--;
            if (rem == 0) begin m_done = 1; m_res = pend; end
        end else if (start) begin
            m_busy = 1;
            pend = ref_res(int'(A), int'(B), {l, e, g});
            rem = ref_lat(int'(A), int'(B));
        end

    // per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (chk_en) begin
            checks++;
            if ({busy, done, lt, et, gt} !== {m_busy, m_done, m_res}) begin
                errors++;
                $display("FAIL cycle %0d: {busy,done,lt,et,gt}=%b required %b", cyc,
                         {busy, done, lt, et, gt}, {m_busy, m_done, m_res});
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic run(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] leg, input logic [2:0] er, input int el);
        int n = 1;
        bit found = 0;
        A = a; B = b; {l, e, g} = leg; start = 1;
        @(posedge clk); #2;
        start = 0; A = W'($urandom); B = W'($urandom); {l, e, g} = 3'($urandom);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1; else n++;
        end
        check({nm, " done seen"}, int'(found), 1);
        check({nm, " latency"}, n, el);
        check({nm, " result"}, int'({lt, et, gt}), int'(er));
        @(posedge clk); #2;
    endtask

    initial begin
        int q[$];
        int snap;
        repeat (2) @(posedge clk);
        #2;
        check("reset outputs", int'({busy, done, lt, et, gt}), 0);
        rst_n = 1;
        chk_en = 1;
        @(posedge clk); #2;

        run("t1 C5>45",   8'hC5, 8'h45, 3'b010, 3'b001, 2);
        run("t2 2A<2B",   8'h2A, 8'h2B, 3'b010, 3'b100, 4);
        run("t3 eq l",    8'h77, 8'h77, 3'b100, 3'b100, 4);
        run("t3 eq e",    8'h77, 8'h77, 3'b010, 3'b010, 4);
        run("t3 eq lg",   8'h77, 8'h77, 3'b011, 3'b011, 4);
        run("eq zero 111", 8'h00, 8'h00, 3'b111, 3'b111, 4);
        run("FF>FE",      8'hFF, 8'hFE, 3'b000, 3'b001, 4);
        run("80>7F",      8'h80, 8'h7F, 3'b100, 3'b001, 2);

        // second start while busy must be ignored
        snap = done_cnt;
        A = 8'h00; B = 8'hFF; {l, e, g} = 3'b010; start = 1;
        @(posedge clk); #2;
        start = 0;
        @(posedge clk); #2;
        A = 8'hFF; B = 8'h00; start = 1;
        @(posedge clk); #2;
        start = 0;
        repeat (8) @(posedge clk);
        #2;
        check("t4 done pulses", done_cnt - snap, 1);
        check("t4 result", int'({lt, et, gt}), 3'b100);

        // reset in the middle of COMPARE aborts with no done pulse
        A = 8'h2A; B = 8'h2B; start = 1;
        @(posedge clk); #2;
        start = 0;
        @(posedge clk); #2;
        snap = done_cnt;
        rst_n = 0;
        #1;
        check("t5 async clear", int'({busy, done, lt, et, gt}), 0);
        @(posedge clk); #2;
        rst_n = 1;
        repeat (5) @(posedge clk);
        #2;
        check("t5 no done", done_cnt - snap, 0);
        run("t5 10>0F", 8'h10, 8'h0F, 3'b000, 3'b001, 3);

        // held start: one accept every 5 cycles
        A = 8'h01; B = 8'h02; {l, e, g} = 3'b000; start = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                q.push_back(cyc);
                check("t6 result", int'({lt, et, gt}), 3'b100);
            end
        end
        start = 0;
        check("t6 pulse count", q.size(), 4);
        for (int i = 1; i < q.size(); i++) check("t6 interval", q[i] - q[i-1], 5);
        repeat (8) @(posedge clk);
        #2;
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
